psion_lcd_capture: RTL and testbench

Receive-side decoder for the Psion 5MX LCD bus: samples the 4-bit panel bus (shift clock, row latch, frame marker, data, enable) and rebuilds the image as packed bytes written into a frame-buffer RAM port. It sits in the same FPGA as the LCD driver, either on looped-back pins or tapping a real Psion's panel cable. Its uses are self-checking the driver in hardware and capturing the host's screen for forwarding to the Pi.

---
 rtl/psion_lcd_pkg.sv | 19 +
 rtl/psion_sync_edge.sv | 39 +++
 rtl/psion_lcd_capture.sv | 208 ++++++++++++++++++++
 tb/tb_psion_lcd_capture.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psion_lcd_pkg.sv
`default_nettype none
// ============================================================================
// psion_lcd_pkg
//   Shared panel geometry and capture state encoding for the Psion 5MX LCD bus.
//   Revision: 1.0
// ============================================================================
package psion_lcd_pkg;

  localparam int unsigned c_width_nibbles_default = 160;
  localparam int unsigned c_height_default        = 240;
  localparam int unsigned c_addr_w_default        = 15;
  localparam int unsigned c_bytes_per_row_default = c_width_nibbles_default / 2;

  typedef logic [0:0] lcd_state_t;
  localparam lcd_state_t c_st_unlocked = 1'b0;
  localparam lcd_state_t c_st_active   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/psion_sync_edge.sv
`default_nettype none
// ============================================================================
// psion_sync_edge
//   Two-flop synchronizer with registered rise/fall detection on stage two.
//   Revision: 1.0
// ============================================================================
module psion_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q, rise_q, fall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
      fall_q <= ~s2_q & s3_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/psion_lcd_capture.sv
`default_nettype none
// ============================================================================
// psion_lcd_capture
//   Decodes the Psion 5MX panel bus back into packed frame-buffer byte writes.
//   Revision: 1.0
// ============================================================================
module psion_lcd_capture
  import psion_lcd_pkg::*;
#(
  parameter int unsigned WIDTH_NIBBLES = c_width_nibbles_default,
  parameter int unsigned HEIGHT        = c_height_default,
  parameter int unsigned ADDR_W        = c_addr_w_default
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lcd_clk_i,
  input  logic              lcd_row_i,
  input  logic              lcd_frame_i,
  input  logic [3:0]        lcd_data_i,
  input  logic              lcd_enable_i,
  output logic              fb_we_o,
  output logic [ADDR_W-1:0] fb_addr_o,
  output logic [7:0]        fb_data_o,
  output logic              frame_done_o,
  output logic              locked_o,
  output logic              err_o,
  output logic [15:0]       frame_count_o
);

  localparam int unsigned c_xw = $clog2(WIDTH_NIBBLES + 1);
  localparam int unsigned c_yw = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [c_xw-1:0] c_x_end  = c_xw'(WIDTH_NIBBLES);
  localparam logic [c_yw-1:0] c_y_last = c_yw'(HEIGHT - 1);

  logic w_nib, w_row, w_en;
  logic w_clk_level, w_clk_rise, w_row_level, w_row_fall, w_en_rise, w_en_fall;
  logic w_unused;

  psion_sync_edge u_sync_clk (
    .clk(clk), .reset(reset), .d_i(lcd_clk_i),
    .level_o(w_clk_level), .rise_o(w_clk_rise), .fall_o(w_nib)
  );
  psion_sync_edge u_sync_row (
    .clk(clk), .reset(reset), .d_i(lcd_row_i),
    .level_o(w_row_level), .rise_o(w_row), .fall_o(w_row_fall)
  );
  psion_sync_edge u_sync_en (
    .clk(clk), .reset(reset), .d_i(lcd_enable_i),
    .level_o(w_en), .rise_o(w_en_rise), .fall_o(w_en_fall)
  );

  assign w_unused = ^{w_clk_level, w_clk_rise, w_row_level, w_row_fall, w_en_rise, w_en_fall};

  // Third stage lines data/frame up with the registered edge events.
  logic [3:0] data1_q, data2_q, data3_q;
  logic       frame1_q, frame2_q, frame3_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data1_q  <= 4'd0;
      data2_q  <= 4'd0;
      data3_q  <= 4'd0;
      frame1_q <= 1'b0;
      frame2_q <= 1'b0;
      frame3_q <= 1'b0;
    end else begin
      data1_q  <= lcd_data_i;
      data2_q  <= data1_q;
      data3_q  <= data2_q;
      frame1_q <= lcd_frame_i;
      frame2_q <= frame1_q;
      frame3_q <= frame2_q;
    end
  end

  lcd_state_t        state_q, state_d;
  logic [c_xw-1:0]   x_q, x_d;
  logic [c_yw-1:0]   y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        hold_q, hold_d;
  logic              half_q, half_d;
  logic              w_clear;
  logic              we_d, err_d, done_d;

  logic              fb_we_q, frame_done_q, err_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [7:0]        fb_data_q;
  logic [15:0]       frame_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= c_st_unlocked;
      x_q           <= '0;
      y_q           <= '0;
      addr_q        <= '0;
      hold_q        <= 4'd0;
      half_q        <= 1'b0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= 8'd0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      hold_q       <= hold_d;
      half_q       <= half_d;
      fb_we_q      <= we_d;
      frame_done_q <= done_d;
      err_q        <= err_d;
      if (we_d) begin
        fb_addr_q <= addr_q;
        fb_data_q <= {hold_q, data3_q};
      end
      if (done_d) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    half_d  = half_q;
    w_clear = 1'b0;
    if (!w_en) begin
      state_d = c_st_unlocked;
      w_clear = 1'b1;
    end else if (state_q == c_st_unlocked) begin
      if (w_row && !w_nib && frame3_q) begin
        state_d = c_st_active;
        w_clear = 1'b1;
      end
    end else if (w_nib && w_row) begin
      state_d = c_st_unlocked;
      w_clear = 1'b1;
    end else if (w_nib) begin
      if (x_q == c_x_end) begin
        state_d = c_st_unlocked;
        w_clear = 1'b1;
      end else begin
        x_d = x_q + c_xw'(1);
        if (!half_q) begin
          hold_d = data3_q;
          half_d = 1'b1;
        end else begin
          half_d = 1'b0;
          addr_d = addr_q + ADDR_W'(1);
        end
      end
    end else if (w_row) begin
      if (x_q != c_x_end) begin
        state_d = c_st_unlocked;
        w_clear = 1'b1;
      end else if (!frame3_q) begin
        if (y_q != c_y_last) begin
          y_d = y_q + c_yw'(1);
          x_d = '0;
        end else begin
          state_d = c_st_unlocked;
          w_clear = 1'b1;
        end
      end else begin
        // Frame marker always restarts counting; only the timing decides err vs done.
        w_clear = 1'b1;
      end
    end
    if (w_clear) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
      half_d = 1'b0;
    end
  end

  always_comb begin
    we_d   = 1'b0;
    err_d  = 1'b0;
    done_d = 1'b0;
    if (w_en && state_q == c_st_active) begin
      if (w_nib && w_row) begin
        err_d = 1'b1;
      end else if (w_nib) begin
        if (x_q == c_x_end) err_d = 1'b1;
        else                we_d  = half_q;
      end else if (w_row) begin
        if (x_q != c_x_end)          err_d  = 1'b1;
        else if (!frame3_q)          err_d  = (y_q == c_y_last);
        else if (y_q == c_y_last)    done_d = 1'b1;
        else                         err_d  = 1'b1;
      end
    end
  end

  assign fb_we_o       = fb_we_q;
  assign fb_addr_o     = fb_addr_q;
  assign fb_data_o     = fb_data_q;
  assign frame_done_o  = frame_done_q;
  assign err_o         = err_q;
  assign locked_o      = (state_q == c_st_active);
  assign frame_count_o = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_psion_lcd_capture.sv
`default_nettype none
// ============================================================================
// tb_psion_lcd_capture
//   Self-checking bench for psion_lcd_capture on a reduced 8x4 panel.
//   Revision: 1.0
// ============================================================================
module tb_psion_lcd_capture;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          lcd_clk = 1'b0, lcd_row = 1'b0, lcd_frame = 1'b0, lcd_enable = 1'b1;
  logic [3:0]    lcd_data = 4'd0;
  logic          fb_we, frame_done, locked, err;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data;
  logic [15:0]   frame_count;

  psion_lcd_capture #(.WIDTH_NIBBLES(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .lcd_clk_i(lcd_clk), .lcd_row_i(lcd_row), .lcd_frame_i(lcd_frame),
    .lcd_data_i(lcd_data), .lcd_enable_i(lcd_enable),
    .fb_we_o(fb_we), .fb_addr_o(fb_addr), .fb_data_o(fb_data),
    .frame_done_o(frame_done), .locked_o(locked), .err_o(err),
    .frame_count_o(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  typedef struct {
    int bad_row; int bad_len; bit end_mark;
    int exp_wr; int exp_err; int exp_done; bit exp_lock;
  } vec_t;

  wr_t sb[$];
  wr_t obs[$];
  int  n_wr = 0, n_err = 0, n_done = 0;
  int  n_cmp = 0, n_fail = 0;
  int  exp_fc = 0;
  int  s_wr, s_err, s_done;

  // Reference model of the expected byte writes.
  bit         m_act = 1'b0;
  int         mx = 0, my = 0, maddr = 0;
  logic [3:0] mhold = 4'd0;

  always @(negedge clk) begin
    if (fb_we) begin
      obs.push_back('{a: fb_addr, d: fb_data});
      n_wr = n_wr + 1;
    end
    if (err)        n_err  = n_err + 1;
    if (frame_done) n_done = n_done + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic model_nib(input logic [3:0] d);
    if (m_act) begin
      if (mx == W) m_act = 1'b0;
      else begin
        if (mx % 2 == 1) begin
          sb.push_back('{a: AW'(maddr), d: {mhold, d}});
          maddr = maddr + 1;
        end else mhold = d;
        mx = mx + 1;
      end
    end
  endtask

  task automatic model_row(input bit f);
    if (!m_act) begin
      if (f) begin m_act = 1'b1; mx = 0; my = 0; maddr = 0; end
    end else if (mx != W) m_act = 1'b0;
    else if (!f) begin
      if (my < H - 1) begin my = my + 1; mx = 0; end
      else m_act = 1'b0;
    end else begin mx = 0; my = 0; maddr = 0; end
  endtask

  task automatic nib(input logic [3:0] d);
    lcd_data = d;
    lcd_clk  = 1'b1;
    repeat (4) @(posedge clk);
    #1 lcd_clk = 1'b0;
    model_nib(d);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic row(input bit f);
    lcd_frame = f;
    lcd_row   = 1'b1;
    model_row(f);
    repeat (4) @(posedge clk);
    #1 lcd_row = 1'b0;
    repeat (4) @(posedge clk);
    #1 lcd_frame = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic enable_drop();
    lcd_enable = 1'b0;
    m_act = 1'b0;
    repeat (6) @(posedge clk);
    #1 lcd_enable = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_wr = n_wr; s_err = n_err; s_done = n_done;
  endtask

  task automatic drain();
    wr_t o, e;
    while (obs.size() > 0) begin
      o = obs.pop_front();
      if (sb.size() == 0) check("extra_write_addr", int'(o.a), -1);
      else begin
        e = sb.pop_front();
        check("wr_addr", int'(o.a), int'(e.a));
        check("wr_data", int'(o.d), int'(e.d));
      end
    end
    check("missing_writes", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_frame(input bit do_lock, input int bad_row, input int bad_len, input bit end_mark);
    int n;
    if (do_lock) row(1'b1);
    for (int r = 0; r < H; r++) begin
      n = (r == bad_row) ? bad_len : W;
      for (int i = 0; i < n; i++) nib(4'(i));
      row((r == H - 1) ? end_mark : 1'b0);
    end
  endtask

  vec_t vt[5];

  initial begin
    vt[0] = '{bad_row: -1, bad_len: 0, end_mark: 1'b1, exp_wr: 16, exp_err: 0, exp_done: 1, exp_lock: 1'b1};
    vt[1] = '{bad_row:  1, bad_len: 6, end_mark: 1'b1, exp_wr:  7, exp_err: 1, exp_done: 0, exp_lock: 1'b1};
    vt[2] = '{bad_row:  2, bad_len: 9, end_mark: 1'b1, exp_wr: 12, exp_err: 1, exp_done: 0, exp_lock: 1'b1};
    vt[3] = '{bad_row:  0, bad_len: 7, end_mark: 1'b1, exp_wr:  3, exp_err: 1, exp_done: 0, exp_lock: 1'b1};
    vt[4] = '{bad_row: -1, bad_len: 0, end_mark: 1'b0, exp_wr: 16, exp_err: 1, exp_done: 0, exp_lock: 1'b0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_we", int'(fb_we), 0);
    check("rst_addr", int'(fb_addr), 0);
    check("rst_data", int'(fb_data), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_fcount", int'(frame_count), 0);
    settle();

    for (int v = 0; v < 5; v++) begin
      snap();
      run_frame(1'b1, vt[v].bad_row, vt[v].bad_len, vt[v].end_mark);
      settle();
      exp_fc = exp_fc + vt[v].exp_done;
      check($sformatf("v%0d_writes", v), n_wr - s_wr, vt[v].exp_wr);
      check($sformatf("v%0d_errs", v), n_err - s_err, vt[v].exp_err);
      check($sformatf("v%0d_dones", v), n_done - s_done, vt[v].exp_done);
      check($sformatf("v%0d_locked", v), int'(locked), int'(vt[v].exp_lock));
      check($sformatf("v%0d_fcount", v), int'(frame_count), exp_fc);
      drain();
      enable_drop();
    end

    // Bus activity without a frame marker must never lock.
    snap();
    for (int i = 0; i < 20; i++) nib(4'(i));
    for (int r = 0; r < 3; r++) row(1'b0);
    settle();
    check("prelock_writes", n_wr - s_wr, 0);
    check("prelock_errs", n_err - s_err, 0);
    check("prelock_locked", int'(locked), 0);
    drain();

    // Write latency relative to the lcd_clk fall.
    row(1'b1);
    check("lock_rise", int'(locked), 1);
    nib(4'd0);
    lcd_data = 4'd1;
    lcd_clk  = 1'b1;
    repeat (4) @(posedge clk);
    #1 lcd_clk = 1'b0;
    model_nib(4'd1);
    repeat (3) @(posedge clk);
    #1 check("lat_n2_we", int'(fb_we), 0);
    @(posedge clk);
    #1 check("lat_n3_we", int'(fb_we), 1);
    check("lat_n3_addr", int'(fb_addr), 0);
    check("lat_n3_data", int'(fb_data), 8'h01);
    @(posedge clk);
    #1 check("lat_we_single", int'(fb_we), 0);
    settle();
    drain();
    enable_drop();

    // Enable loss mid-frame, then recovery on the next marker.
    snap();
    row(1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < W; i++) nib(4'(i));
      row(1'b0);
    end
    for (int i = 0; i < 3; i++) nib(4'(i));
    lcd_enable = 1'b0;
    m_act = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("endrop_locked", int'(locked), 0);
    settle();
    check("endrop_errs", n_err - s_err, 0);
    check("endrop_writes", n_wr - s_wr, 9);
    lcd_enable = 1'b1;
    settle();
    snap();
    run_frame(1'b1, -1, 0, 1'b1);
    settle();
    exp_fc = exp_fc + 1;
    check("recover_dones", n_done - s_done, 1);
    check("recover_errs", n_err - s_err, 0);
    check("recover_fcount", int'(frame_count), exp_fc);
    drain();
    enable_drop();

    // Three back-to-back frames.
    snap();
    run_frame(1'b1, -1, 0, 1'b1);
    run_frame(1'b0, -1, 0, 1'b1);
    run_frame(1'b0, -1, 0, 1'b1);
    settle();
    exp_fc = exp_fc + 3;
    check("multi_dones", n_done - s_done, 3);
    check("multi_errs", n_err - s_err, 0);
    check("multi_writes", n_wr - s_wr, 3 * W / 2 * H);
    check("multi_fcount", int'(frame_count), exp_fc);
    check("multi_locked", int'(locked), 1);
    drain();
    enable_drop();

    // Reset landing between an lcd_clk fall and its write.
    row(1'b1);
    nib(4'd0);
    nib(4'd1);
    nib(4'd2);
    snap();
    lcd_data = 4'd3;
    lcd_clk  = 1'b1;
    repeat (4) @(posedge clk);
    #1 lcd_clk = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    m_act = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    settle();
    check("rstmid_writes", n_wr - s_wr, 0);
    check("rstmid_locked", int'(locked), 0);
    check("rstmid_fcount", int'(frame_count), 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
